// File: rtl/run_monitor.sv
// Run monitor: counts per-core retired fetches until every core fetches a zero (halt) word,
// then drains for a fixed number of cycles. A watchdog bounds the run length.

module run_monitor_lane #(
   parameter int INST_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  run,
   input  logic                  valid,
   input  logic [INST_WIDTH-1:0] word,
   output logic                  halted,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  inc
);
   logic                 halted_q, halted_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 take;

   assign take = run & valid & ~halted_q;

   always_comb begin
      halted_d = halted_q;
      count_d  = count_q;
      inc      = take & (word != '0);
      if (clr) begin
         halted_d = 1'b0;
         count_d  = '0;
      end else if (take) begin
         if (word == '0)
            halted_d = 1'b1;
         else if (count_q != '1)
            count_d = count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         halted_q <= 1'b0;
         count_q  <= '0;
      end else begin
         halted_q <= halted_d;
         count_q  <= count_d;
      end
   end

   assign halted = halted_q;
   assign count  = count_q;
endmodule

module run_monitor #(
   parameter int NUM_CORES       = 4,
   parameter int INST_WIDTH      = 32,
   parameter int CNT_WIDTH       = 32,
   parameter int DRAIN_CYCLES    = 3,
   parameter int WATCHDOG_CYCLES = 25000
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [NUM_CORES-1:0]              inst_valid,
   input  logic [0:NUM_CORES*INST_WIDTH-1]   inst_in,
   output logic                              busy,
   output logic                              done,
   output logic                              timeout,
   output logic [NUM_CORES-1:0]              halted,
   output logic [CNT_WIDTH-1:0]              cycle_count,
   output logic [0:NUM_CORES*CNT_WIDTH-1]    inst_count,
   output logic [CNT_WIDTH-1:0]              total_inst
);
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int PW = $clog2(NUM_CORES + 1);
   localparam int SW = CNT_WIDTH + PW;
   localparam logic [CNT_WIDTH-1:0]    CNT_MAX    = '1;
   localparam logic [DW-1:0]           DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
   // Compared at extended width so a limit beyond the counter range never aliases.
   localparam logic [CNT_WIDTH+31:0]   WD_LAST    = (CNT_WIDTH+32)'(WATCHDOG_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_TIMEOUT} state_e;

   state_e               state_q, state_d;
   logic                 busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
   logic [CNT_WIDTH-1:0] cycle_q, cycle_d, total_q, total_d;
   logic [DW-1:0]        drain_q, drain_d;
   logic [NUM_CORES-1:0] inc, halted_w;
   logic                 clr, run, wd_hit, all_halted;
   logic [PW-1:0]        pop;
   logic [SW-1:0]        tsum;

   assign all_halted = &halted_w;
   assign wd_hit     = ({32'd0, cycle_q} == WD_LAST);
   assign clr        = start & (state_q == S_IDLE || state_q == S_DONE || state_q == S_TIMEOUT);
   assign run        = (state_q == S_RUN);

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_lane
      run_monitor_lane #(.INST_WIDTH(INST_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_lane (
         .clk    (clk),
         .reset  (reset),
         .clr    (clr),
         .run    (run),
         .valid  (inst_valid[c]),
         .word   (inst_in[c*INST_WIDTH +: INST_WIDTH]),
         .halted (halted_w[c]),
         .count  (inst_count[c*CNT_WIDTH +: CNT_WIDTH]),
         .inc    (inc[c])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Watchdog wins over both the halt-driven and the drain-driven transitions.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_TIMEOUT: if (start) state_d = S_RUN;
         S_RUN: begin
            if (wd_hit)          state_d = S_TIMEOUT;
            else if (all_halted) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (wd_hit)                      state_d = S_TIMEOUT;
            else if (drain_q == DRAIN_LAST)  state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d    = (state_d == S_DONE);
      timeout_d = (state_d == S_TIMEOUT);
   end

   always_comb begin
      cycle_d = cycle_q;
      total_d = total_q;
      drain_d = '0;
      pop     = '0;
      for (int i = 0; i < NUM_CORES; i++) pop = pop + PW'(inc[i]);
      tsum = SW'(total_q) + SW'(pop);
      if (clr) begin
         cycle_d = '0;
         total_d = '0;
      end else if (state_q == S_RUN || state_q == S_DRAIN) begin
         if (cycle_q != CNT_MAX) cycle_d = cycle_q + CNT_WIDTH'(1);
         total_d = (tsum > SW'(CNT_MAX)) ? CNT_MAX : tsum[CNT_WIDTH-1:0];
      end
      if (state_q == S_DRAIN) drain_d = drain_q + DW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         cycle_q   <= '0;
         total_q   <= '0;
         drain_q   <= '0;
      end else begin
         busy_q    <= busy_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         cycle_q   <= cycle_d;
         total_q   <= total_d;
         drain_q   <= drain_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign halted      = halted_w;
   assign cycle_count = cycle_q;
   assign total_inst  = total_q;
endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: three parameterisations driven together, each tracked by a
// run-level reference model; directed scenarios plus randomized runs.

module tb_run_monitor;
   logic clk, reset, st;
   // instance A: 4 cores, 16-bit counters, drain 3, watchdog 64
   logic [3:0] va;  logic [0:31] ia;  logic ba, da, ta;  logic [3:0] ha;
   logic [15:0] ca, sa;  logic [0:63] na;
   // instance B: 1 core, 4-bit counters, drain 3, default watchdog
   logic [0:0] vb;  logic [0:7] ib;  logic bb, db, tb_;  logic [0:0] hb;
   logic [3:0] cb, sb;  logic [0:3] nb;
   // instance C: 2 cores, 8-bit counters, drain 2, watchdog 16
   logic [1:0] vc;  logic [0:15] ic;  logic bc, dc, tc;  logic [1:0] hc;
   logic [7:0] cc, sc;  logic [0:15] ncc;

   int n_err = 0, n_chk = 0;

   run_monitor #(.NUM_CORES(4), .INST_WIDTH(8), .CNT_WIDTH(16), .DRAIN_CYCLES(3), .WATCHDOG_CYCLES(64)) u_a (
      .clk(clk), .reset(reset), .start(st), .inst_valid(va), .inst_in(ia), .busy(ba), .done(da),
      .timeout(ta), .halted(ha), .cycle_count(ca), .inst_count(na), .total_inst(sa));
   run_monitor #(.NUM_CORES(1), .INST_WIDTH(8), .CNT_WIDTH(4), .DRAIN_CYCLES(3), .WATCHDOG_CYCLES(25000)) u_b (
      .clk(clk), .reset(reset), .start(st), .inst_valid(vb), .inst_in(ib), .busy(bb), .done(db),
      .timeout(tb_), .halted(hb), .cycle_count(cb), .inst_count(nb), .total_inst(sb));
   run_monitor #(.NUM_CORES(2), .INST_WIDTH(8), .CNT_WIDTH(8), .DRAIN_CYCLES(2), .WATCHDOG_CYCLES(16)) u_c (
      .clk(clk), .reset(reset), .start(st), .inst_valid(vc), .inst_in(ic), .busy(bc), .done(dc),
      .timeout(tc), .halted(hc), .cycle_count(cc), .inst_count(ncc), .total_inst(sc));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int ncores(int k); return (k == 0) ? 4 : (k == 1) ? 1 : 2; endfunction
   function automatic int cwid(int k);   return (k == 0) ? 16 : (k == 1) ? 4 : 8; endfunction
   function automatic int drn(int k);    return (k == 2) ? 2 : 3; endfunction
   function automatic longint wdg(int k); return (k == 0) ? 64 : (k == 1) ? 25000 : 16; endfunction

   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3, M_TO = 4;
   int     ms[3];
   int     mleft[3];
   longint mcyc[3], mtot[3];
   longint mcnt[3][4];
   bit     mh[3][4];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         ms[k] = M_IDLE; mleft[k] = 0; mcyc[k] = 0; mtot[k] = 0;
         for (int c = 0; c < 4; c++) begin mcnt[k][c] = 0; mh[k][c] = 1'b0; end
      end
   endtask

   task automatic model_step(int k, bit s, bit [3:0] v, logic [3:0][7:0] w);
      longint mx, old;
      bit     allh;
      int     n;
      mx = (longint'(1) << cwid(k)) - 1;
      old = mcyc[k];
      allh = 1'b1;
      n = 0;
      case (ms[k])
         M_IDLE, M_DONE, M_TO: if (s) begin
            mcyc[k] = 0; mtot[k] = 0;
            for (int c = 0; c < 4; c++) begin mcnt[k][c] = 0; mh[k][c] = 1'b0; end
            ms[k] = M_RUN;
         end
         M_RUN: begin
            for (int c = 0; c < ncores(k); c++) allh = allh & mh[k][c];
            if (mcyc[k] < mx) mcyc[k]++;
            for (int c = 0; c < ncores(k); c++)
               if (v[c] && !mh[k][c]) begin
                  if (w[c] != 8'h00) begin
                     n++;
                     if (mcnt[k][c] < mx) mcnt[k][c]++;
                  end else mh[k][c] = 1'b1;
               end
            mtot[k] = (mtot[k] + n > mx) ? mx : mtot[k] + n;
            if (old == wdg(k) - 1) ms[k] = M_TO;
            else if (allh) begin ms[k] = M_DRAIN; mleft[k] = drn(k); end
         end
         M_DRAIN: begin
            if (mcyc[k] < mx) mcyc[k]++;
            mleft[k]--;
            if (old == wdg(k) - 1) ms[k] = M_TO;
            else if (mleft[k] == 0) ms[k] = M_DONE;
         end
         default: ;
      endcase
   endtask

   task automatic model_all();
      logic [3:0][7:0] w;
      for (int c = 0; c < 4; c++) w[c] = ia[c*8 +: 8];
      model_step(0, st, va, w);
      w = '0; w[0] = ib;
      model_step(1, st, {3'b0, vb}, w);
      w = '0; w[0] = ic[0 +: 8]; w[1] = ic[8 +: 8];
      model_step(2, st, {2'b0, vc}, w);
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         logic b, d, t;
         logic [3:0] h, eh;
         logic [31:0] cy, tt;
         logic [31:0] cn[4];
         for (int c = 0; c < 4; c++) cn[c] = '0;
         case (k)
            0: begin
               b = ba; d = da; t = ta; h = ha; cy = 32'(ca); tt = 32'(sa);
               for (int c = 0; c < 4; c++) cn[c] = 32'(na[c*16 +: 16]);
            end
            1: begin
               b = bb; d = db; t = tb_; h = {3'b0, hb}; cy = 32'(cb); tt = 32'(sb);
               cn[0] = 32'(nb);
            end
            default: begin
               b = bc; d = dc; t = tc; h = {2'b0, hc}; cy = 32'(cc); tt = 32'(sc);
               cn[0] = 32'(ncc[0 +: 8]); cn[1] = 32'(ncc[8 +: 8]);
            end
         endcase
         eh = '0;
         for (int c = 0; c < ncores(k); c++) eh[c] = mh[k][c];
         chk($sformatf("i%0d_busy", k), 32'(b), 32'(ms[k] == M_RUN || ms[k] == M_DRAIN));
         chk($sformatf("i%0d_done", k), 32'(d), 32'(ms[k] == M_DONE));
         chk($sformatf("i%0d_timeout", k), 32'(t), 32'(ms[k] == M_TO));
         chk($sformatf("i%0d_halted", k), 32'(h), 32'(eh));
         chk($sformatf("i%0d_cycle", k), cy, 32'(mcyc[k]));
         chk($sformatf("i%0d_total", k), tt, 32'(mtot[k]));
         for (int c = 0; c < ncores(k); c++)
            chk($sformatf("i%0d_cnt%0d", k, c), cn[c], 32'(mcnt[k][c]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_all();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      #1;
      reset = 1'b1;
   endtask

   task automatic clear_inputs();
      st = 1'b0; va = '0; ia = '0; vb = '0; ib = '0; vc = '0; ic = '0;
   endtask

   function automatic logic [7:0] rword(int zp);
      if (int'($urandom % 32'(zp)) == 0) return 8'h00;
      return 8'($urandom_range(1, 255));
   endfunction

   task automatic rand_inputs(int zp);
      va = 4'($urandom);
      for (int c = 0; c < 4; c++) ia[c*8 +: 8] = rword(zp);
      vb = 1'($urandom);
      ib = rword(zp);
      vc = 2'($urandom);
      for (int c = 0; c < 2; c++) ic[c*8 +: 8] = rword(zp);
   endtask

   int halt_at[4] = '{3, 5, 9, 12};
   int zps[3] = '{3, 12, 200};

   initial begin
      reset = 1'b0;
      clear_inputs();
      #1;
      model_reset();
      check_all();
      chk("rst_cycle_a", 32'(ca), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // five words, a halt word, then drain; start held during drain must not matter
      clear_inputs();
      st = 1'b1; tick(); st = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         vb = 1'b1; ib = (e == 6) ? 8'h00 : 8'(e * 16 + 1);
         tick();
      end
      vb = 1'b0; ib = '0;
      for (int e = 7; e <= 10; e++) begin
         st = (e == 8 || e == 9);
         tick();
      end
      st = 1'b0;
      chk("r20_done", 32'(db), 32'd1);
      chk("r20_busy", 32'(bb), 32'd0);
      chk("r20_cycle", 32'(cb), 32'd10);
      chk("r20_cnt", 32'(nb), 32'd5);
      chk("r20_total", 32'(sb), 32'd5);

      // staggered halts on four cores, valid held high
      @(negedge clk); do_reset(); clear_inputs();
      st = 1'b1; tick(); st = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         va = 4'hF;
         for (int c = 0; c < 4; c++)
            ia[c*8 +: 8] = (e == halt_at[c]) ? 8'h00 :
                           (e < halt_at[c]) ? 8'($urandom_range(1, 255)) : rword(3);
         st = (e == 14 || e == 15);
         tick();
         if (e == 13) chk("r21_busy13", 32'(ba), 32'd1);
      end
      st = 1'b0;
      chk("r21_done", 32'(da), 32'd1);
      chk("r21_cnt0", 32'(na[0 +: 16]), 32'd2);
      chk("r21_cnt1", 32'(na[16 +: 16]), 32'd4);
      chk("r21_cnt2", 32'(na[32 +: 16]), 32'd8);
      chk("r21_cnt3", 32'(na[48 +: 16]), 32'd11);
      chk("r21_total", 32'(sa), 32'd25);
      chk("r21_halted", 32'(ha), 32'hF);
      chk("r21_cycle", 32'(ca), 32'd16);

      // watchdog on instance C, then restart
      @(negedge clk); do_reset(); clear_inputs();
      st = 1'b1; tick(); st = 1'b0;
      for (int e = 1; e <= 19; e++) begin
         vc = 2'b11;
         ic = {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
         tick();
         if (e == 16) begin
            chk("r22_timeout", 32'(tc), 32'd1);
            chk("r22_done", 32'(dc), 32'd0);
            chk("r22_cycle", 32'(cc), 32'd16);
            chk("r22_total", 32'(sc), 32'd32);
         end
      end
      chk("r22_frozen_cycle", 32'(cc), 32'd16);
      chk("r22_frozen_cnt", 32'(ncc[0 +: 8]), 32'd16);
      st = 1'b1; tick(); st = 1'b0;
      chk("r22_restart_cycle", 32'(cc), 32'd0);
      chk("r22_restart_busy", 32'(bc), 32'd1);
      chk("r22_restart_to", 32'(tc), 32'd0);

      // saturation on the 4-bit instance
      @(negedge clk); do_reset(); clear_inputs();
      st = 1'b1; tick(); st = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         vb = 1'b1; ib = 8'($urandom_range(1, 255));
         tick();
      end
      chk("r23_cnt", 32'(nb), 32'hF);
      chk("r23_total", 32'(sb), 32'hF);
      chk("r23_cycle", 32'(cb), 32'hF);
      ib = 8'h00; tick();
      vb = 1'b0;
      repeat (4) tick();
      chk("r23_done", 32'(db), 32'd1);
      chk("r23_cnt_held", 32'(nb), 32'hF);

      // async reset mid-run, then idle until start
      @(negedge clk); do_reset(); clear_inputs();
      st = 1'b1; tick(); st = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         rand_inputs(200);
         st = (e == 3);
         tick();
      end
      st = 1'b0;
      reset = 1'b0;
      #1;
      model_reset();
      chk("r24_busy", 32'(ba), 32'd0);
      chk("r24_cycle", 32'(ca), 32'd0);
      chk("r24_total", 32'(sa), 32'd0);
      chk("r24_cnt0", 32'(na[0 +: 16]), 32'd0);
      check_all();
      #1;
      reset = 1'b1;
      for (int e = 0; e < 4; e++) begin rand_inputs(3); tick(); end
      chk("r24_idle_busy", 32'(ba), 32'd0);

      // randomized runs with occasional start pulses
      for (int r = 0; r < 24; r++) begin
         int zp, len;
         zp = zps[r % 3];
         len = int'($urandom_range(10, 80));
         clear_inputs();
         st = 1'b1; tick(); st = 1'b0;
         for (int e = 0; e < len; e++) begin
            rand_inputs(zp);
            st = ($urandom % 16 == 0);
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
